regfile_mp: RTL and testbench
=============================

// Module: regfile_mp
// PURPOSE
//  Parametrised multi-port integer register file with a pending-write scoreboard, for the next NPC core.
//  Provides NREAD combinational read ports and NWRITE synchronous write ports.
//  x0 is hardwired to zero. Optional write-to-read bypass is included.
//  A per-register busy bit lets decode stall on RAW hazards until writeback clears the bit.
//  Sits between decode (read/issue) and writeback (write).
// PARAMETERS
//  XLEN     32  data width of each register
//  NREG     32  number of architectural registers (power of two, >=2); AW = $clog2(NREG)
//  NREAD    2   number of read ports
//  NWRITE   2   number of write ports
//  BYPASS   1   1: read of a register being written this cycle returns the write data; 0: returns the old value
// PORTS
//  clk        in   1             clock; all state updates on rising edge
//  rst        in   1             synchronous, active-high reset
//  raddr      in   NREAD*AW      read addresses, port r at [r*AW +: AW]
//  rdata      out  NREAD*XLEN    read data, port r at [r*XLEN +: XLEN]
//  rbusy      out  NREAD         busy bit of the register addressed by read port r
//  wen        in   NWRITE        write enable per write port
//  waddr      in   NWRITE*AW     write addresses
//  wdata      in   NWRITE*XLEN   write data
//  issue_en   in   1             mark issue_addr as pending (producer issued)
//  issue_addr in   AW            destination register of the issued producer
//  dbg_addr   in   AW            debug/test read address; no bypass applied
//  dbg_data   out  XLEN          contents of dbg_addr
// BEHAVIOUR
//  - Reset: all registers load 0 and all busy bits clear on the first rising clk edge with rst=1.
//    rdata, rbusy and dbg_data are then 0. Reset wins over any write or issue in that cycle.
//  - Reads: rdata is combinational with zero latency. Reading address 0 always yields 0 and rbusy=0.
//  - Writes: on the clk edge, when wen[w]=1 and waddr[w]!=0, reg[waddr[w]] <= wdata[w].
//    Writes to x0 are dropped silently.
//  - Write collision: several ports enabled to the same nonzero address -> the highest-index port wins.
//  - Bypass (BYPASS=1): when raddr[r] matches an enabled nonzero waddr, rdata gets that wdata in the same cycle.
//    The collision priority above also applies to the bypassed value. With BYPASS=0, rdata shows the old value
//    until the next cycle.
//  - Scoreboard, per register i!=0:
//      clear when any enabled write port targets i;
//      set when issue_en=1 and issue_addr==i.
//    Set and clear in the same cycle -> set wins (the newer producer is pending).
//    busy[0] is constant 0. issue_en with issue_addr=0 has no effect.
//  - rbusy[r] = busy[raddr[r]], registered value. It does not clear combinationally on a same-cycle write;
//    consumers rely on bypass for that case.
//  - Mid-operation reset: pending issues are discarded. No write in the reset cycle takes effect.
//  - Widths: addresses are taken modulo NREG (AW bits). No sign handling; data is opaque.
// STRUCTURE
//  - Package regfile_pkg: XLEN/NREG defaults, the AW computation function, and the ZERO_REG localparam.
//  - Sub-module regfile_rd_port: one instance per read port, via generate.
//    It handles the array select, the x0 override and the priority bypass mux.
//    Same parameters as the top, minus NREAD.
//  - Storage and scoreboard are generate loops in the top.
//  - No vendor memory macros; flop-based so that NWRITE>1 is supported.
// TESTING
//  1. Reset: write x5=0xDEADBEEF, then assert rst for 1 cycle -> next cycle rdata(x5)=0 and all rbusy=0.
//  2. x0: wen[0]=1, waddr=0, wdata=0xFFFFFFFF -> rdata(x0)=0 both same cycle and next cycle;
//     issue_addr=0 -> rbusy stays 0.
//  3. Bypass: with BYPASS=1, write x7=0x12345678 while raddr[1]=7 -> rdata[1]=0x12345678 in the same cycle.
//     With BYPASS=0 -> old value that cycle, new value the next cycle.
//  4. Collision: port0 writes x3=0x1111 and port1 writes x3=0x2222 in the same cycle
//     -> bypassed and stored value are 0x2222.
//  5. Scoreboard: issue x9 -> rbusy=1 from the next cycle. Write x9 two cycles later -> rbusy=0 the following cycle.
//     Issue x9 and write x9 in the same cycle -> busy remains 1.
//  6. Random: 10k cycles of random reads, writes and issues against a reference model.
//     Compare rdata, rbusy and dbg_data every cycle, with random rst pulses mixed in.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the multi-port integer register file.
// Imported by the top and the read-port sub-module.
package regfile_pkg;

  localparam int DEFAULT_XLEN = 32;
  localparam int DEFAULT_NREG = 32;
  localparam int ZERO_REG     = 0;

  // A single-register file would make $clog2 return 0, so keep at least one address bit.
  function automatic int addr_width(input int nreg);
    return (nreg < 2) ? 1 : $clog2(nreg);
  endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// One combinational read port: array select, x0 override and priority write bypass.
// The highest-index matching write port wins, matching the storage collision rule.
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int XLEN   = DEFAULT_XLEN,
  parameter int NREG   = DEFAULT_NREG,
  parameter int NWRITE = 2,
  parameter int BYPASS = 1,
  localparam int AW    = addr_width(NREG)
) (
  input  logic [AW-1:0]              raddr,
  input  logic [NREG-1:0][XLEN-1:0]  regs,
  input  logic [NREG-1:0]            busy,
  input  logic [NWRITE-1:0]          wen,
  input  logic [NWRITE*AW-1:0]       waddr,
  input  logic [NWRITE*XLEN-1:0]     wdata,
  output logic [XLEN-1:0]            rdata,
  output logic                       rbusy
);

  always_comb begin
    rdata = regs[raddr];
    if (BYPASS != 0) begin
      for (int w = 0; w < NWRITE; w++) begin
        if (wen[w] && (waddr[w*AW +: AW] == raddr)) begin
          rdata = wdata[w*XLEN +: XLEN];
        end
      end
    end
    if (raddr == AW'(ZERO_REG)) begin
      rdata = '0;
    end
    rbusy = busy[raddr];
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with x0 hardwired to zero and a per-register
// pending-write scoreboard; flop-based so any number of write ports is supported.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN   = DEFAULT_XLEN,
  parameter int NREG   = DEFAULT_NREG,
  parameter int NREAD  = 2,
  parameter int NWRITE = 2,
  parameter int BYPASS = 1,
  localparam int AW    = addr_width(NREG)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREAD*AW-1:0]     raddr,
  output logic [NREAD*XLEN-1:0]   rdata,
  output logic [NREAD-1:0]        rbusy,
  input  logic [NWRITE-1:0]       wen,
  input  logic [NWRITE*AW-1:0]    waddr,
  input  logic [NWRITE*XLEN-1:0]  wdata,
  input  logic                    issue_en,
  input  logic [AW-1:0]           issue_addr,
  input  logic [AW-1:0]           dbg_addr,
  output logic [XLEN-1:0]         dbg_data
);

  logic [NREG-1:0][XLEN-1:0] regs;
  logic [NREG-1:0]           busy;

  assign regs[ZERO_REG] = '0;
  assign busy[ZERO_REG] = 1'b0;

  for (genvar i = 1; i < NREG; i++) begin : g_reg
    logic [XLEN-1:0] value;
    logic            pending;
    logic            write_hit;

    always_comb begin
      write_hit = 1'b0;
      for (int w = 0; w < NWRITE; w++) begin
        if (wen[w] && (waddr[w*AW +: AW] == AW'(i))) begin
          write_hit = 1'b1;
        end
      end
    end

    // Later ports overwrite earlier ones, so the highest-index port wins a collision.
    always_ff @(posedge clk) begin
      if (rst) begin
        value <= '0;
      end else begin
        for (int w = 0; w < NWRITE; w++) begin
          if (wen[w] && (waddr[w*AW +: AW] == AW'(i))) begin
            value <= wdata[w*XLEN +: XLEN];
          end
        end
      end
    end

    // A same-cycle issue beats the clear: the newer producer is still outstanding.
    always_ff @(posedge clk) begin
      if (rst) begin
        pending <= 1'b0;
      end else if (issue_en && (issue_addr == AW'(i))) begin
        pending <= 1'b1;
      end else if (write_hit) begin
        pending <= 1'b0;
      end
    end

    assign regs[i] = value;
    assign busy[i] = pending;
  end

  for (genvar r = 0; r < NREAD; r++) begin : g_rd
    regfile_rd_port #(
      .XLEN  (XLEN),
      .NREG  (NREG),
      .NWRITE(NWRITE),
      .BYPASS(BYPASS)
    ) u_rd_port (
      .raddr(raddr[r*AW +: AW]),
      .regs (regs),
      .busy (busy),
      .wen  (wen),
      .waddr(waddr),
      .wdata(wdata),
      .rdata(rdata[r*XLEN +: XLEN]),
      .rbusy(rbusy[r])
    );
  end

  assign dbg_data = regs[dbg_addr];

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed scenarios followed by random
// traffic compared against an array-based reference model of the register file.
module tb_regfile_mp;

  localparam int XLEN   = 32;
  localparam int NREG   = 32;
  localparam int NREAD  = 2;
  localparam int NWRITE = 2;
  localparam int AW     = 5;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NREAD*AW-1:0]    raddr;
  logic [NREAD*XLEN-1:0]  rdata;
  logic [NREAD-1:0]       rbusy;
  logic [NWRITE-1:0]      wen;
  logic [NWRITE*AW-1:0]   waddr;
  logic [NWRITE*XLEN-1:0] wdata;
  logic                   issue_en;
  logic [AW-1:0]          issue_addr;
  logic [AW-1:0]          dbg_addr;
  logic [XLEN-1:0]        dbg_data;

  int checks   = 0;
  int failures = 0;

  logic [XLEN-1:0] m_regs [NREG];
  logic            m_busy [NREG];

  regfile_mp #(
    .XLEN(XLEN), .NREG(NREG), .NREAD(NREAD), .NWRITE(NWRITE), .BYPASS(1)
  ) dut (
    .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
    .wen(wen), .waddr(waddr), .wdata(wdata), .issue_en(issue_en),
    .issue_addr(issue_addr), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  function automatic logic [XLEN-1:0] rd(input int r);
    return rdata[r*XLEN +: XLEN];
  endfunction

  function automatic logic [AW-1:0] rand_addr();
    // Half the traffic lands on x0..x7 so collisions and bypass hits are frequent.
    if ($urandom_range(0, 1) == 1) return AW'($urandom_range(0, 7));
    return AW'($urandom);
  endfunction

  task automatic idle();
    rst        = 1'b0;
    wen        = '0;
    waddr      = '0;
    wdata      = '0;
    issue_en   = 1'b0;
    issue_addr = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    tick();
    idle();
    wen = 2'b01; waddr[0 +: AW] = 5'd5; wdata[0 +: XLEN] = 32'hDEADBEEF;
    issue_en = 1'b1; issue_addr = 5'd6;
    tick();
    idle();
    raddr = {5'd6, 5'd5}; dbg_addr = 5'd5;
    #1;
    checks++; if (rd(0) !== 32'hDEADBEEF) begin failures++; $display("[TB] FAIL pre_reset_x5: got %h expected %h", rd(0), 32'hDEADBEEF); end
    checks++; if (rbusy[1] !== 1'b1) begin failures++; $display("[TB] FAIL pre_reset_busy_x6: got %b expected 1", rbusy[1]); end
    rst = 1'b1;
    wen = 2'b01; waddr[0 +: AW] = 5'd5; wdata[0 +: XLEN] = 32'h00000001;
    issue_en = 1'b1; issue_addr = 5'd5;
    tick();
    idle();
    #1;
    checks++; if (rd(0) !== 32'h0) begin failures++; $display("[TB] FAIL reset_x5: got %h expected 0", rd(0)); end
    checks++; if (rbusy !== 2'b00) begin failures++; $display("[TB] FAIL reset_rbusy: got %b expected 00", rbusy); end
    checks++; if (dbg_data !== 32'h0) begin failures++; $display("[TB] FAIL reset_dbg: got %h expected 0", dbg_data); end
  endtask

  task automatic test_x0();
    idle();
    wen = 2'b01; waddr[0 +: AW] = 5'd0; wdata[0 +: XLEN] = 32'hFFFFFFFF;
    issue_en = 1'b1; issue_addr = 5'd0;
    raddr = '0; dbg_addr = 5'd0;
    #1;
    checks++; if (rd(0) !== 32'h0) begin failures++; $display("[TB] FAIL x0_same_cycle: got %h expected 0", rd(0)); end
    tick();
    idle();
    #1;
    checks++; if (rd(1) !== 32'h0) begin failures++; $display("[TB] FAIL x0_next_cycle: got %h expected 0", rd(1)); end
    checks++; if (rbusy !== 2'b00) begin failures++; $display("[TB] FAIL x0_rbusy: got %b expected 00", rbusy); end
    checks++; if (dbg_data !== 32'h0) begin failures++; $display("[TB] FAIL x0_dbg: got %h expected 0", dbg_data); end
  endtask

  task automatic test_bypass();
    idle();
    raddr = {5'd7, 5'd0}; dbg_addr = 5'd7;
    wen = 2'b10; waddr[AW +: AW] = 5'd7; wdata[XLEN +: XLEN] = 32'h12345678;
    #1;
    checks++; if (rd(1) !== 32'h12345678) begin failures++; $display("[TB] FAIL bypass_same_cycle: got %h expected %h", rd(1), 32'h12345678); end
    checks++; if (dbg_data !== 32'h0) begin failures++; $display("[TB] FAIL dbg_no_bypass: got %h expected 0", dbg_data); end
    tick();
    idle();
    #1;
    checks++; if (rd(1) !== 32'h12345678) begin failures++; $display("[TB] FAIL bypass_stored: got %h expected %h", rd(1), 32'h12345678); end
  endtask

  task automatic test_collision();
    idle();
    raddr = {5'd0, 5'd3}; dbg_addr = 5'd3;
    wen = 2'b11;
    waddr[0 +: AW] = 5'd3;  wdata[0 +: XLEN]    = 32'h00001111;
    waddr[AW +: AW] = 5'd3; wdata[XLEN +: XLEN] = 32'h00002222;
    #1;
    checks++; if (rd(0) !== 32'h00002222) begin failures++; $display("[TB] FAIL collision_bypass: got %h expected %h", rd(0), 32'h00002222); end
    tick();
    idle();
    #1;
    checks++; if (dbg_data !== 32'h00002222) begin failures++; $display("[TB] FAIL collision_stored: got %h expected %h", dbg_data, 32'h00002222); end
  endtask

  task automatic test_scoreboard();
    idle();
    raddr = {5'd0, 5'd9};
    issue_en = 1'b1; issue_addr = 5'd9;
    #1;
    checks++; if (rbusy[0] !== 1'b0) begin failures++; $display("[TB] FAIL busy_before_issue: got %b expected 0", rbusy[0]); end
    tick();
    idle();
    #1;
    checks++; if (rbusy[0] !== 1'b1) begin failures++; $display("[TB] FAIL busy_after_issue: got %b expected 1", rbusy[0]); end
    tick();
    wen = 2'b01; waddr[0 +: AW] = 5'd9; wdata[0 +: XLEN] = 32'h00000099;
    #1;
    checks++; if (rbusy[0] !== 1'b1) begin failures++; $display("[TB] FAIL busy_during_write: got %b expected 1", rbusy[0]); end
    tick();
    idle();
    #1;
    checks++; if (rbusy[0] !== 1'b0) begin failures++; $display("[TB] FAIL busy_after_write: got %b expected 0", rbusy[0]); end
    issue_en = 1'b1; issue_addr = 5'd9;
    wen = 2'b10; waddr[AW +: AW] = 5'd9; wdata[XLEN +: XLEN] = 32'h0000009A;
    tick();
    idle();
    #1;
    checks++; if (rbusy[0] !== 1'b1) begin failures++; $display("[TB] FAIL busy_issue_and_write: got %b expected 1", rbusy[0]); end
  endtask

  task automatic test_random();
    logic [AW-1:0]   a;
    logic [XLEN-1:0] exp;
    idle();
    rst = 1'b1;
    for (int i = 0; i < NREG; i++) begin m_regs[i] = '0; m_busy[i] = 1'b0; end
    tick();
    for (int c = 0; c < 10000; c++) begin
      rst        = ($urandom_range(0, 63) == 0);
      wen        = NWRITE'($urandom);
      for (int w = 0; w < NWRITE; w++) begin
        waddr[w*AW +: AW]     = rand_addr();
        wdata[w*XLEN +: XLEN] = $urandom;
      end
      issue_en   = $urandom_range(0, 1) == 1;
      issue_addr = rand_addr();
      for (int r = 0; r < NREAD; r++) raddr[r*AW +: AW] = rand_addr();
      dbg_addr   = rand_addr();
      #1;
      for (int r = 0; r < NREAD; r++) begin
        a   = raddr[r*AW +: AW];
        exp = m_regs[a];
        for (int w = 0; w < NWRITE; w++)
          if (wen[w] && waddr[w*AW +: AW] == a) exp = wdata[w*XLEN +: XLEN];
        if (a == 0) exp = '0;
        checks++; if (rd(r) !== exp) begin failures++; $display("[TB] FAIL rand_rdata%0d cycle %0d addr %0d: got %h expected %h", r, c, a, rd(r), exp); end
        checks++; if (rbusy[r] !== m_busy[a]) begin failures++; $display("[TB] FAIL rand_rbusy%0d cycle %0d addr %0d: got %b expected %b", r, c, a, rbusy[r], m_busy[a]); end
      end
      checks++; if (dbg_data !== m_regs[dbg_addr]) begin failures++; $display("[TB] FAIL rand_dbg cycle %0d addr %0d: got %h expected %h", c, dbg_addr, dbg_data, m_regs[dbg_addr]); end
      @(posedge clk);
      if (rst) begin
        for (int i = 0; i < NREG; i++) begin m_regs[i] = '0; m_busy[i] = 1'b0; end
      end else begin
        for (int w = 0; w < NWRITE; w++) begin
          a = waddr[w*AW +: AW];
          if (wen[w] && a != 0) begin
            m_regs[a] = wdata[w*XLEN +: XLEN];
            m_busy[a] = 1'b0;
          end
        end
        if (issue_en && issue_addr != 0) m_busy[issue_addr] = 1'b1;
      end
      @(negedge clk);
    end
    idle();
  endtask

  initial begin
    idle();
    raddr    = '0;
    dbg_addr = '0;
    test_reset();
    test_x0();
    test_bypass();
    test_collision();
    test_scoreboard();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
